// File: rtl/uart_imem_loader.sv
// Boot-time UART (8N1) program loader: receives a length-prefixed image and writes it into imem.
// Optional trailing checksum byte is enabled by defining UART_IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps

module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int WL_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam longint unsigned CAPACITY = 64'd1 << ADDR_W;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DONE,
        S_ERR
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } ld_state_t;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    ld_state_t        state_q, state_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [WL_W-1:0]  len_q, len_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      word_q, word_d;
    logic             imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]      imem_wdata_q, imem_wdata_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic             load_done_q, load_done_d;
    logic             load_error_q, load_error_d;
    logic [WL_W-1:0]  words_loaded_q, words_loaded_d;
    logic [15:0]      len_word;
    logic             finish;
    logic             fail;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    // Two-flop synchronizer plus one delayed copy for start-bit edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    clk_cnt_d  = '0;
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d    = '0;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                    rx_state_d   = RX_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign len_word = {shift_q, len_lo_q};

    // Framing: length header, then 4-byte LE words; termination waits for the final write strobe
    always_comb begin
        state_d        = state_q;
        len_lo_d       = len_lo_q;
        len_d          = len_q;
        byte_cnt_d     = byte_cnt_q;
        word_d         = word_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        cpu_hold_d     = cpu_hold_q;
        load_done_d    = load_done_q;
        load_error_d   = load_error_q;
        words_loaded_d = words_loaded_q;
        finish         = 1'b0;
        fail           = 1'b0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        case (state_q)
            S_LEN0: begin
                if (frame_err_q) begin
                    fail = 1'b1;
                end else if (byte_valid_q) begin
                    len_lo_d = shift_q;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (frame_err_q) begin
                    fail = 1'b1;
                end else if (byte_valid_q) begin
                    if (len_word == 16'd0) begin
                        finish = 1'b1;
                    end else if (64'(len_word) > CAPACITY) begin
                        fail = 1'b1;
                    end else begin
                        len_d      = WL_W'(len_word);
                        byte_cnt_d = '0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (frame_err_q) begin
                    fail = 1'b1;
                end else if (byte_valid_q) begin
                    word_d[8*byte_cnt_q +: 8] = shift_q;
                    byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q + shift_q;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d      = 1'b1;
                        imem_addr_d    = words_loaded_q[ADDR_W-1:0];
                        imem_wdata_d   = {shift_q, word_q[23:0]};
                        words_loaded_d = words_loaded_q + 1'b1;
                    end
                end else if (imem_we_q && (words_loaded_q == len_q)) begin
                    finish = 1'b1;
                end
            end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (frame_err_q) begin
                    fail = 1'b1;
                end else if (byte_valid_q) begin
                    if (shift_q == csum_q) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
`endif
            S_DONE: ;
            S_ERR:  ;
            default: ;
        endcase

        if (finish) begin
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d     = S_DONE;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
`endif
        end
        if (fail) begin
            state_d      = S_ERR;
            load_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_LEN0;
            len_lo_q       <= '0;
            len_q          <= '0;
            byte_cnt_q     <= '0;
            word_q         <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            cpu_hold_q     <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
            words_loaded_q <= '0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            len_lo_q       <= len_lo_d;
            len_q          <= len_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_hold_q     <= cpu_hold_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
            words_loaded_q <= words_loaded_d;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed testbench for uart_imem_loader (CLKS_PER_BIT=16, ADDR_W=4).
// Appends checksum bytes when UART_IMEM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps

module tb_uart_imem_loader;

    localparam int CPB = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          uart_rx = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    int pass_cnt  = 0;
    int check_cnt = 0;

    int            wr_cnt = 0;
    logic [AW-1:0] wr_addr [64];
    logic [31:0]   wr_data [64];
    logic          wr_hold [64];

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Record every cycle the write strobe is high; a stretched strobe shows up as an extra write
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = imem_addr;
                wr_data[wr_cnt] = imem_wdata;
                wr_hold[wr_cnt] = cpu_hold;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        uart_rx = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_flags(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (load_done === 1'b1 || load_error === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_cnt++;
        if ({imem_we, imem_addr, imem_wdata} !== '0)
            $display("[TB] FAIL reset_write_port: got we=%b addr=%h data=%h expected all 0", imem_we, imem_addr, imem_wdata);
        else pass_cnt++;
        check_cnt++;
        if ({cpu_hold, load_done, load_error} !== 3'b100)
            $display("[TB] FAIL reset_status: got hold/done/err=%b expected 100", {cpu_hold, load_done, load_error});
        else pass_cnt++;
        check_cnt++;
        if (words_loaded !== 5'd0)
            $display("[TB] FAIL reset_words: got %0d expected 0", words_loaded);
        else pass_cnt++;
    endtask

    task automatic test_two_words();
        int base;
        bit to;
        do_reset();
        base = wr_cnt;
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h50, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h07, 1'b1);
`endif
        wait_flags(200, to);
        check_cnt++;
        if (to) $display("[TB] FAIL two_words_timeout: got no done/error expected done");
        else pass_cnt++;
        check_cnt++;
        if (wr_cnt - base !== 2) $display("[TB] FAIL two_words_count: got %0d expected 2", wr_cnt - base);
        else pass_cnt++;
        check_cnt++;
        if (wr_addr[base] !== 4'd0 || wr_data[base] !== 32'h00500093)
            $display("[TB] FAIL two_words_w0: got addr=%h data=%h expected 0/00500093", wr_addr[base], wr_data[base]);
        else pass_cnt++;
        check_cnt++;
        if (wr_addr[base+1] !== 4'd1 || wr_data[base+1] !== 32'h00100113)
            $display("[TB] FAIL two_words_w1: got addr=%h data=%h expected 1/00100113", wr_addr[base+1], wr_data[base+1]);
        else pass_cnt++;
        check_cnt++;
        if (wr_hold[base+1] !== 1'b1) $display("[TB] FAIL two_words_hold_during_write: got %b expected 1", wr_hold[base+1]);
        else pass_cnt++;
        check_cnt++;
        if ({load_done, cpu_hold, load_error} !== 3'b100 || words_loaded !== 5'd2)
            $display("[TB] FAIL two_words_final: got done/hold/err=%b words=%0d expected 100 words=2",
                     {load_done, cpu_hold, load_error}, words_loaded);
        else pass_cnt++;
    endtask

    task automatic test_zero_len();
        int base;
        bit to;
        do_reset();
        base = wr_cnt;
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b1);
`endif
        wait_flags(200, to);
        check_cnt++;
        if (to || load_done !== 1'b1 || cpu_hold !== 1'b0)
            $display("[TB] FAIL zero_len_done: got done=%b hold=%b expected done=1 hold=0", load_done, cpu_hold);
        else pass_cnt++;
        check_cnt++;
        if (wr_cnt - base !== 0 || words_loaded !== 5'd0)
            $display("[TB] FAIL zero_len_writes: got writes=%0d words=%0d expected 0/0", wr_cnt - base, words_loaded);
        else pass_cnt++;
    endtask

    task automatic test_too_long();
        int base;
        bit to;
        do_reset();
        base = wr_cnt;
        send_byte(8'h11, 1'b1); send_byte(8'h00, 1'b1);
        wait_flags(200, to);
        check_cnt++;
        if (to || load_error !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0)
            $display("[TB] FAIL too_long_error: got err=%b hold=%b done=%b expected 1/1/0", load_error, cpu_hold, load_done);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b1);
        check_cnt++;
        if (wr_cnt - base !== 0 || load_error !== 1'b1 || load_done !== 1'b0)
            $display("[TB] FAIL too_long_ignored: got writes=%0d err=%b done=%b expected 0/1/0", wr_cnt - base, load_error, load_done);
        else pass_cnt++;
    endtask

    // N == 2^ADDR_W is the largest image accepted: every address gets written once
    task automatic test_full_capacity();
        int base;
        bit to;
        do_reset();
        base = wr_cnt;
        send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        for (int w = 0; w < 16; w++)
            for (int k = 0; k < 4; k++)
                send_byte(8'(w * 4 + k), 1'b1);
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hE0, 1'b1);
`endif
        wait_flags(200, to);
        check_cnt++;
        if (to || load_done !== 1'b1 || load_error !== 1'b0)
            $display("[TB] FAIL full_done: got done=%b err=%b expected 1/0", load_done, load_error);
        else pass_cnt++;
        check_cnt++;
        if (wr_cnt - base !== 16 || words_loaded !== 5'd16)
            $display("[TB] FAIL full_count: got writes=%0d words=%0d expected 16/16", wr_cnt - base, words_loaded);
        else pass_cnt++;
        check_cnt++;
        if (wr_addr[base+15] !== 4'd15 || wr_data[base+15] !== 32'h3F3E3D3C)
            $display("[TB] FAIL full_last_word: got addr=%h data=%h expected f/3f3e3d3c", wr_addr[base+15], wr_data[base+15]);
        else pass_cnt++;
        check_cnt++;
        if (wr_addr[base+6] !== 4'd6 || wr_data[base+6] !== 32'h1B1A1918)
            $display("[TB] FAIL full_mid_word: got addr=%h data=%h expected 6/1b1a1918", wr_addr[base+6], wr_data[base+6]);
        else pass_cnt++;
    endtask

    task automatic test_frame_error();
        int base;
        bit to;
        do_reset();
        base = wr_cnt;
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        wait_flags(200, to);
        check_cnt++;
        if (to || load_error !== 1'b1 || load_done !== 1'b0 || cpu_hold !== 1'b1)
            $display("[TB] FAIL frame_err_status: got err=%b done=%b hold=%b expected 1/0/1", load_error, load_done, cpu_hold);
        else pass_cnt++;
        send_byte(8'hDD, 1'b1);
        check_cnt++;
        if (wr_cnt - base !== 0) $display("[TB] FAIL frame_err_writes: got %0d expected 0", wr_cnt - base);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int base;
        bit to;
        do_reset();
        base = wr_cnt;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h38, 1'b1);
`endif
        wait_flags(200, to);
        check_cnt++;
        if (to || load_done !== 1'b1 || load_error !== 1'b0)
            $display("[TB] FAIL glitch_done: got done=%b err=%b expected 1/0", load_done, load_error);
        else pass_cnt++;
        check_cnt++;
        if (wr_cnt - base !== 1 || wr_addr[base] !== 4'd0 || wr_data[base] !== 32'hDEADBEEF)
            $display("[TB] FAIL glitch_write: got n=%0d addr=%h data=%h expected 1/0/deadbeef",
                     wr_cnt - base, wr_addr[base], wr_data[base]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_load();
        int base;
        bit to;
        do_reset();
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h44, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h11, 1'b1);
        send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
        check_cnt++;
        if (words_loaded !== 5'd1 || imem_wdata !== 32'h11223344)
            $display("[TB] FAIL midload_progress: got words=%0d data=%h expected 1/11223344", words_loaded, imem_wdata);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        check_cnt++;
        if (words_loaded !== 5'd0 || imem_wdata !== 32'd0 || cpu_hold !== 1'b1 || load_done !== 1'b0 || imem_we !== 1'b0)
            $display("[TB] FAIL midload_async_reset: got words=%0d data=%h hold=%b done=%b we=%b expected 0/0/1/0/0",
                     words_loaded, imem_wdata, cpu_hold, load_done, imem_we);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        base = wr_cnt;
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h14, 1'b1);
`endif
        wait_flags(200, to);
        check_cnt++;
        if (to || load_done !== 1'b1 || wr_cnt - base !== 1 || wr_addr[base] !== 4'd0 || wr_data[base] !== 32'h12345678)
            $display("[TB] FAIL midload_fresh_load: got done=%b n=%0d addr=%h data=%h expected 1/1/0/12345678",
                     load_done, wr_cnt - base, wr_addr[base], wr_data[base]);
        else pass_cnt++;
    endtask

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int base;
        bit to;
        do_reset();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        wait_flags(200, to);
        check_cnt++;
        if (to || load_done !== 1'b1 || load_error !== 1'b0)
            $display("[TB] FAIL csum_good: got done=%b err=%b expected 1/0", load_done, load_error);
        else pass_cnt++;
        do_reset();
        base = wr_cnt;
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h14, 1'b1);
        wait_flags(200, to);
        check_cnt++;
        if (to || load_error !== 1'b1 || load_done !== 1'b0 || cpu_hold !== 1'b1)
            $display("[TB] FAIL csum_bad: got err=%b done=%b hold=%b expected 1/0/1", load_error, load_done, cpu_hold);
        else pass_cnt++;
        check_cnt++;
        if (wr_cnt - base !== 1 || wr_data[base] !== 32'h00000013)
            $display("[TB] FAIL csum_bad_write: got n=%0d data=%h expected 1/00000013", wr_cnt - base, wr_data[base]);
        else pass_cnt++;
    endtask
`endif

    initial begin
        $display("[TB] starting uart_imem_loader bench");
        test_reset();
        test_two_words();
        test_zero_len();
        test_too_long();
        test_full_capacity();
        test_frame_error();
        test_glitch();
        test_reset_mid_load();
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
